// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_seq_ctrl
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait
//               timeout faults. Define CORE_SEQ_PERF_CNT_EN for cycle/instret counters.
// Revision    : 1.0 - initial release
// ============================================================================
module core_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        rf_wEn_in,
    input  logic        illegal,
    output logic        imem_req,
    output logic        ir_en,
    output logic        dmem_req,
    output logic        dmem_wEn,
    output logic        rf_wEn,
    output logic        pc_en,
    output logic        halted,
    output logic [1:0]  fault,
`ifdef CORE_SEQ_PERF_CNT_EN
    output logic [31:0] cycle_count,
    output logic [31:0] instret,
`endif
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] c_FAULT_NONE    = 2'b00;
    localparam logic [1:0] c_FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] c_FAULT_IMEM    = 2'b10;
    localparam logic [1:0] c_FAULT_DMEM    = 2'b11;
    localparam logic [7:0] c_TIMEOUT       = 8'(TIMEOUT_CYCLES);

    state_t     r_state;
    logic [7:0] r_wait;
    logic [1:0] r_fault;
    logic       w_timeout;

    assign w_timeout = (r_wait == c_TIMEOUT);

    // The wait counter defaults to zero, so any state change clears it; it only
    // counts up while FETCH or MEM is held waiting for its ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_wait  <= 8'd0;
            r_fault <= c_FAULT_NONE;
        end else begin
            r_wait <= 8'd0;
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_state <= ST_DECODE;
                    end else if (w_timeout) begin
                        r_state <= ST_HALT;
                        r_fault <= c_FAULT_IMEM;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_DECODE: begin
                    if (illegal) begin
                        r_state <= ST_HALT;
                        r_fault <= c_FAULT_ILLEGAL;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state <= (is_load || is_store) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        r_state <= ST_WB;
                    end else if (w_timeout) begin
                        r_state <= ST_HALT;
                        r_fault <= c_FAULT_DMEM;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode the state register; ir_en and the data/regfile strobes
    // also follow same-cycle handshake and decode inputs.
    assign state    = r_state;
    assign fault    = r_fault;
    assign halted   = (r_state == ST_HALT);
    assign imem_req = (r_state == ST_FETCH);
    assign ir_en    = (r_state == ST_FETCH) && imem_ready;
    assign dmem_req = (r_state == ST_MEM);
    assign dmem_wEn = (r_state == ST_MEM) && is_store;
    assign pc_en    = (r_state == ST_WB);
    assign rf_wEn   = (r_state == ST_WB) && rf_wEn_in && !is_store;

`ifdef CORE_SEQ_PERF_CNT_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_instret;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle_count <= 32'd0;
            r_instret     <= 32'd0;
        end else begin
            if (r_state != ST_IDLE && r_state != ST_HALT)
                r_cycle_count <= r_cycle_count + 32'd1;
            if (r_state == ST_WB)
                r_instret <= r_instret + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
    assign instret     = r_instret;
`endif

endmodule
`default_nettype wire

// File: doc/core_seq_ctrl.md
CORE_SEQ_CTRL -- requirements
Module: core_seq_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum memory wait cycles before a fault (legal range 1..255).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1: leave IDLE and begin fetching.
REQ-005 The block SHALL have port imem_ready, input, 1: instruction memory data valid this cycle.
REQ-006 The block SHALL have port dmem_ready, input, 1: data memory access complete this cycle.
REQ-007 The block SHALL have ports is_load, is_store, rf_wEn_in and illegal, each input, 1 bit, all from decode: load opcode, store opcode, decoded register write enable, and unsupported opcode.
REQ-008 The block SHALL have port imem_req, output, 1: instruction fetch request.
REQ-009 The block SHALL have port ir_en, output, 1: capture the instruction register.
REQ-010 The block SHALL have port dmem_req, output, 1: data memory request.
REQ-011 The block SHALL have port dmem_wEn, output, 1: data memory write strobe.
REQ-012 The block SHALL have port rf_wEn, output, 1: gated register file write enable.
REQ-013 The block SHALL have port pc_en, output, 1: advance the PC register.
REQ-014 The block SHALL have port halted, output, 1: HALT state reached.
REQ-015 The block SHALL have port fault, output, 2: halt cause, where 00 means none, 01 means illegal, 10 means imem timeout and 11 means dmem timeout.
REQ-016 The block SHALL have port state, output, 3: current state encoding, where IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5 and HALT=6.

Function
REQ-017 The FSM SHALL be one-hot-free binary with states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT, registered on clock.
REQ-018 In IDLE, start=1 SHALL move the FSM to FETCH on the next edge; otherwise it SHALL remain in IDLE.
REQ-019 In FETCH, imem_req SHALL be 1.
REQ-020 In FETCH, imem_ready=1 SHALL assert ir_en combinationally in the same cycle and move the FSM to DECODE.
REQ-021 DECODE SHALL last exactly one cycle: illegal=1 SHALL move to HALT with fault=01; otherwise the FSM SHALL move to EXEC.
REQ-022 EXEC SHALL last exactly one cycle, moving to MEM when is_load or is_store is 1, else to WB.
REQ-023 In MEM, dmem_req SHALL be 1, dmem_wEn SHALL equal is_store, and dmem_ready=1 SHALL move the FSM to WB.
REQ-024 WB SHALL last exactly one cycle with pc_en=1, rf_wEn = rf_wEn_in AND NOT is_store, then move to FETCH.
REQ-025 rf_wEn, pc_en, dmem_req and dmem_wEn SHALL be 0 in every state other than those stated above.
REQ-026 Instruction latency with zero-wait memories SHALL be 4 cycles for ALU/branch instructions and 5 cycles for load/store.
REQ-027 An 8-bit wait counter SHALL clear on every state change and increment each cycle spent in FETCH without imem_ready or in MEM without dmem_ready.
REQ-028 When the wait counter equals TIMEOUT_CYCLES and ready is still 0, the FSM SHALL go to HALT with fault=10 (FETCH) or 11 (MEM).
REQ-029 A ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL take priority; there SHALL be no fault.
REQ-030 HALT SHALL be absorbing until reset; halted=1 and all request and enable outputs SHALL be 0 in HALT.
REQ-031 start SHALL be ignored in every state except IDLE.

Reset
REQ-032 reset=1 SHALL force state=IDLE, fault=00, wait counter=0, and all outputs 0 on the next edge, overriding every transition including a pending ready.
REQ-033 Reset asserted mid-MEM SHALL drop dmem_req and dmem_wEn in the cycle after the reset edge, and no WB SHALL follow.

Configuration
REQ-034 With macro CORE_SEQ_PERF_CNT_EN defined, the block SHALL add 32-bit outputs cycle_count and instret.
REQ-035 cycle_count SHALL increment each cycle the FSM is not in IDLE or HALT.
REQ-036 instret SHALL increment on each WB cycle.
REQ-037 Both counters SHALL wrap from 0xFFFFFFFF to 0, clear on reset, and freeze in HALT.
REQ-038 Without CORE_SEQ_PERF_CNT_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-039 The bench SHALL cover: reset, start=1, imem_ready tied 1, ALU op -> states 1,2,3,5,1, pc_en pulses once every 4 cycles, rf_wEn=1 in WB.
REQ-040 The bench SHALL cover: store with dmem_ready high after 3 cycles in MEM -> dmem_wEn=1 for 4 cycles, rf_wEn=0 in WB, instret+1.
REQ-041 The bench SHALL cover: TIMEOUT_CYCLES=4 with imem_ready held 0 -> HALT after 5 FETCH cycles, fault=10, halted=1.
REQ-042 The bench SHALL cover: imem_ready=1 on the exact timeout cycle -> DECODE entered, fault=00.
REQ-043 The bench SHALL cover: illegal=1 in DECODE -> HALT, fault=01, start pulse ignored, and reset returns to IDLE.
REQ-044 The bench SHALL cover: reset pulsed during MEM with dmem_ready=1 -> IDLE next cycle, no rf_wEn and no pc_en.
